alu_issue_arbiter: RTL and testbench
====================================

// Module: alu_issue_arbiter
// PURPOSE
//  Shares the single ALU execute slot between NUM_REQ issue-queue requesters.
//  Each cycle it picks one valid requester by round-robin and latches its issue payload into a one-entry output register.
//  The output register drives the ALU's issue_to_alu_valid / issue_inst inputs.
//  Sits between the issue queues and the ALU; obeys the ALU valid/allowin handshake and the pipeline flush.
// PARAMETERS
//  NUM_REQ    4   number of requesters; 2..8
//  PAYLOAD_W  128 bits per issue payload; $bits(issue_to_execute_bus_t) in the core
//  ID_W       $clog2(NUM_REQ)  width of the grant index
// PORTS
//  clk                 in   1                   clock
//  reset               in   1                   asynchronous, active-high reset
//  flush               in   1                   pipeline flush; synchronous, one-cycle pulse
//  req_valid           in   NUM_REQ             requester i presents a valid payload
//  req_payload         in   NUM_REQ*PAYLOAD_W   payload i occupies bits [i*PAYLOAD_W +: PAYLOAD_W]
//  req_ready           out  NUM_REQ             one-hot; payload i is consumed this cycle
//  alu_allowin         in   1                   ALU can accept a new instruction
//  issue_to_alu_valid  out  1                   output register holds a valid instruction
//  issue_inst          out  PAYLOAD_W           registered payload to the ALU
//  grant_id            out  ID_W                requester index of the registered payload
// BEHAVIOUR
//  State: out_valid, out_payload, grant_id, rr_ptr[ID_W]. All reset to 0 asynchronously.
//   - issue_to_alu_valid = out_valid, issue_inst = out_payload.
//  load_en = !flush && (alu_allowin || !out_valid).
//  Arbitration (combinational):
//   - Scan indices rr_ptr, rr_ptr+1, ... mod NUM_REQ.
//   - The first i with req_valid[i]=1 wins; win_any = |req_valid.
//  req_ready[i] = load_en && win_any && (i == winner). At most one bit is set. It never depends on req_ready itself.
//  Clock edge, in priority order:
//   - reset: out_valid, out_payload, grant_id and rr_ptr all go to 0.
//   - flush: out_valid <= 0. out_payload, grant_id and rr_ptr hold. No requester is consumed.
//   - load_en && win_any:
//       out_valid <= 1, out_payload <= req_payload[winner], grant_id <= winner.
//       rr_ptr <= winner+1 (wraps NUM_REQ-1 -> 0).
//   - load_en && !win_any: out_valid <= 0. rr_ptr holds.
//   - !load_en (out_valid && !alu_allowin): all state holds. The payload stays stable while stalled.
//  Latency:
//   - A request accepted in cycle t reaches the ALU inputs in cycle t+1.
//   - Back-to-back acceptance gives 1 instruction/cycle while alu_allowin=1.
//  Fairness: after requester k wins, every other continuously-valid requester wins before k wins again. Starvation bound is NUM_REQ-1 grants.
//  Requesters must hold req_valid and payload stable until req_ready. The arbiter may re-pick among valid requests each cycle.
//  A requester that drops valid before it is granted loses nothing; rr_ptr does not move.
//  Simultaneous flush and alu_allowin: flush wins. Nothing is consumed and the output empties.
//  Reset asserted mid-stall: the output clears immediately and asynchronously; req_ready is 0 while reset is high.
// TESTING
//  1. Reset, then all req_valid=4'b1111 with alu_allowin=1 held:
//     -> grants 0,1,2,3,0 on consecutive cycles; grant_id follows one cycle later.
//  2. req_valid=4'b0101, rr_ptr=1:
//     -> grant 2, then 0, then 2; req_ready never sets bits 1 or 3.
//  3. Load payload 0xA5 from req 3, then hold alu_allowin=0 for 3 cycles with req 0 valid:
//     -> issue_inst stays 0xA5 and req_ready=0.
//     -> On allowin=1, req 0 is granted in the same cycle and its payload appears next cycle.
//  4. flush in the cycle req 1 is valid and alu_allowin=1:
//     -> req_ready=0, next cycle issue_to_alu_valid=0, req 1 granted the cycle after.
//  5. Assert reset asynchronously mid-stall with out_valid=1:
//     -> issue_to_alu_valid drops before the next clock edge; rr_ptr=0 after release.
//  6. Random req_valid/alu_allowin for 10k cycles:
//     -> req_ready is one-hot-or-zero.
//     -> Each accepted payload appears exactly once at issue_inst.
//     -> No valid requester waits more than 3 grants.

Source files
------------

// File: rtl/alu_issue_arbiter.sv
// Round-robin arbiter sharing the single ALU issue slot between NUM_REQ issue queues.
// The winning payload is held in a one-entry output register that obeys the ALU valid/allowin handshake.
module alu_issue_arbiter #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned PAYLOAD_W = 128,
  parameter int unsigned ID_W      = $clog2(NUM_REQ)
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         flush_i,
  input  logic [NUM_REQ-1:0]           req_valid_i,
  input  logic [NUM_REQ*PAYLOAD_W-1:0] req_payload_i,
  output logic [NUM_REQ-1:0]           req_ready_o,
  input  logic                         alu_allowin_i,
  output logic                         issue_to_alu_valid_o,
  output logic [PAYLOAD_W-1:0]         issue_inst_o,
  output logic [ID_W-1:0]              grant_id_o
);

  logic                 out_valid_q, out_valid_d;
  logic [PAYLOAD_W-1:0] out_payload_q, out_payload_d;
  logic [ID_W-1:0]      grant_id_q, grant_id_d;
  logic [ID_W-1:0]      rr_q, rr_d;

  logic            load_en;
  logic            win_any;
  logic [ID_W-1:0] winner;

  assign load_en = !flush_i && (alu_allowin_i || !out_valid_q);

  // Scan forward from rr_q; the first valid index at the smallest offset wins.
  always_comb begin
    int unsigned idx;
    win_any = 1'b0;
    winner  = '0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      idx = (int'(rr_q) + off) % NUM_REQ;
      if (!win_any && req_valid_i[idx]) begin
        win_any = 1'b1;
        winner  = ID_W'(idx);
      end
    end
  end

  always_comb begin
    req_ready_o = '0;
    if (!reset_i && load_en && win_any) begin
      req_ready_o[winner] = 1'b1;
    end
  end

  always_comb begin
    out_valid_d   = out_valid_q;
    out_payload_d = out_payload_q;
    grant_id_d    = grant_id_q;
    rr_d          = rr_q;
    if (flush_i) begin
      out_valid_d = 1'b0;
    end else if (load_en) begin
      if (win_any) begin
        out_valid_d   = 1'b1;
        out_payload_d = req_payload_i[winner*PAYLOAD_W +: PAYLOAD_W];
        grant_id_d    = winner;
        rr_d          = (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + ID_W'(1);
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      out_valid_q   <= 1'b0;
      out_payload_q <= '0;
      grant_id_q    <= '0;
      rr_q          <= '0;
    end else begin
      out_valid_q   <= out_valid_d;
      out_payload_q <= out_payload_d;
      grant_id_q    <= grant_id_d;
      rr_q          <= rr_d;
    end
  end

  assign issue_to_alu_valid_o = out_valid_q;
  assign issue_inst_o         = out_payload_q;
  assign grant_id_o           = grant_id_q;

endmodule

// File: tb/tb_alu_issue_arbiter.sv
// Directed and constrained-random checks for alu_issue_arbiter with four requesters.
module tb_alu_issue_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned PW = 128;

  logic            clk = 1'b0;
  logic            reset;
  logic            flush;
  logic [N-1:0]    req_valid;
  logic [N*PW-1:0] req_payload;
  logic [N-1:0]    req_ready;
  logic            alu_allowin;
  logic            out_valid;
  logic [PW-1:0]   issue_inst;
  logic [1:0]      grant_id;

  logic [PW-1:0] pay [N];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < N; i++) req_payload[i*PW +: PW] = pay[i];
  end

  alu_issue_arbiter #(.NUM_REQ(N), .PAYLOAD_W(PW)) dut (
    .clk_i               (clk),
    .reset_i             (reset),
    .flush_i             (flush),
    .req_valid_i         (req_valid),
    .req_payload_i       (req_payload),
    .req_ready_o         (req_ready),
    .alu_allowin_i       (alu_allowin),
    .issue_to_alu_valid_o(out_valid),
    .issue_inst_o        (issue_inst),
    .grant_id_o          (grant_id)
  );

  task automatic chk(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Random-phase model state
  logic          m_ov;
  logic [PW-1:0] m_pay;
  int            m_gid, m_rr;
  logic [N-1:0]  pend;
  int            waits [N];
  int            seq;

  initial begin
    reset = 1'b1; flush = 1'b0; req_valid = '0; alu_allowin = 1'b0;
    for (int i = 0; i < N; i++) pay[i] = PW'(128'h1000 + i);
    tick(); tick();
    req_valid = 4'b1111;
    #1;
    chk("rst_valid", PW'(out_valid), 0);
    chk("rst_inst", issue_inst, 0);
    chk("rst_gid", PW'(grant_id), 0);
    chk("rst_ready", PW'(req_ready), 0);

    // 1: all valid -> 0,1,2,3,0
    tick();
    reset = 1'b0; alu_allowin = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("t1_ready", PW'(req_ready), PW'(1 << (k % 4)));
      tick();
      chk("t1_gid", PW'(grant_id), PW'(k % 4));
      chk("t1_inst", issue_inst, PW'(128'h1000 + (k % 4)));
      chk("t1_valid", PW'(out_valid), 1);
    end

    // 2: rr_ptr=1, valid 0101 -> 2,0,2
    req_valid = 4'b0101;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("t2_ready", PW'(req_ready), (k == 1) ? PW'(4'b0001) : PW'(4'b0100));
      tick();
      chk("t2_gid", PW'(grant_id), (k == 1) ? 0 : 2);
    end

    // 3: load 0xA5 from req 3, stall 3 cycles, then req 0
    pay[3] = PW'(8'hA5); pay[0] = PW'(8'h5A); req_valid = 4'b1000;
    #1;
    chk("t3_ready3", PW'(req_ready), PW'(4'b1000));
    tick();
    chk("t3_inst", issue_inst, PW'(8'hA5));
    alu_allowin = 1'b0; req_valid = 4'b0001;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("t3_stall_ready", PW'(req_ready), 0);
      tick();
      chk("t3_stall_inst", issue_inst, PW'(8'hA5));
      chk("t3_stall_valid", PW'(out_valid), 1);
    end
    alu_allowin = 1'b1;
    #1;
    chk("t3_release_ready", PW'(req_ready), PW'(4'b0001));
    tick();
    chk("t3_release_inst", issue_inst, PW'(8'h5A));
    chk("t3_release_gid", PW'(grant_id), 0);

    // 4: flush with req 1 valid and allowin=1
    req_valid = 4'b0010; flush = 1'b1;
    #1;
    chk("t4_flush_ready", PW'(req_ready), 0);
    tick();
    chk("t4_flush_valid", PW'(out_valid), 0);
    chk("t4_flush_hold", issue_inst, PW'(8'h5A));
    flush = 1'b0;
    #1;
    chk("t4_ready", PW'(req_ready), PW'(4'b0010));
    tick();
    chk("t4_gid", PW'(grant_id), 1);
    chk("t4_valid", PW'(out_valid), 1);
    chk("t4_inst", issue_inst, PW'(128'h1001));

    // 5: async reset mid-stall
    alu_allowin = 1'b0; req_valid = 4'b1111;
    tick();
    chk("t5_stall_valid", PW'(out_valid), 1);
    #2;
    reset = 1'b1;
    #1;
    chk("t5_async_valid", PW'(out_valid), 0);
    chk("t5_async_inst", issue_inst, 0);
    chk("t5_async_ready", PW'(req_ready), 0);
    tick();
    reset = 1'b0; alu_allowin = 1'b1;
    #1;
    chk("t5_rr_ready", PW'(req_ready), PW'(4'b0001));
    tick();
    chk("t5_rr_gid", PW'(grant_id), 0);

    // 6: random traffic against a reference model
    m_ov = 1'b1; m_pay = pay[0]; m_gid = 0; m_rr = 1;
    pend = '0; seq = 0;
    for (int i = 0; i < N; i++) waits[i] = 0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      logic         le, any;
      int           w;
      logic [N-1:0] exp_rdy;
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(1, 0) == 1) begin
          pend[i] = 1'b1;
          seq++;
          pay[i] = {PW'(seq), 8'(i)};
        end
      end
      req_valid   = pend;
      alu_allowin = ($urandom_range(3, 0) != 0);
      flush       = ($urandom_range(15, 0) == 0);
      #1;
      le  = !flush && (alu_allowin || !m_ov);
      any = 1'b0;
      w   = 0;
      for (int off = 0; off < N; off++) begin
        if (!any && pend[(m_rr + off) % N]) begin
          any = 1'b1;
          w   = (m_rr + off) % N;
        end
      end
      exp_rdy = (le && any) ? N'(1 << w) : '0;
      chk("r_ready", PW'(req_ready), PW'(exp_rdy));
      chk("r_onehot0", PW'($onehot0(req_ready)), 1);
      if (le && any) begin
        for (int i = 0; i < N; i++) begin
          if (i != w && pend[i]) begin
            waits[i]++;
            chk("r_starve", PW'(waits[i] <= 3), 1);
          end
        end
        waits[w] = 0;
      end
      tick();
      if (flush) m_ov = 1'b0;
      else if (le) begin
        if (any) begin
          m_ov = 1'b1; m_pay = pay[w]; m_gid = w; m_rr = (w + 1) % N; pend[w] = 1'b0;
        end else m_ov = 1'b0;
      end
      chk("r_valid", PW'(out_valid), PW'(m_ov));
      if (m_ov) begin
        chk("r_inst", issue_inst, m_pay);
        chk("r_gid", PW'(grant_id), PW'(m_gid));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
